tnn_neuron_scheduler: RTL and testbench
=======================================

# tnn_neuron_scheduler

Time-multiplexes one combinational approximate TNN neuron core (six 3-bit operands a..f, 1-bit fire output) across N_NEURONS neurons of a layer. Per accepted sample, the block routes selected input features to the core once per neuron, collects the fire bits into a result vector, and returns it over a valid/ready handshake. The core sits outside this block on the core_* ports, so evolved approximate variants swap in without RTL changes here.

## Interface
Parameters:
- N_NEURONS, 8: neurons sequenced per sample (2..64).
- N_FEAT, 6: input features per sample (1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_feat  in  3*N_FEAT  features; feature k at bits [3k+2:3k].
- cfg_we  in  1  config write strobe.
- cfg_addr  in  clog2(N_NEURONS)  neuron index.
- cfg_data  in  18  six 3-bit source indices; slot order a,b,c,d,e,f from LSB.
- cfg_err  out  1  one-cycle pulse: write dropped.
- core_a..core_f  out  3 each  operands to the shared core.
- core_out  in  1  core fire bit, combinational from core_*.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts.
- out_result  out  N_NEURONS  bit i = fire of neuron i.
- busy  out  1  high in RUN or DONE.

## Operation
- Source index s: s < N_FEAT selects feature s; s >= N_FEAT (including 7) selects constant 0.
- Config memory: N_NEURONS x 18 bits, each slot reset to 7, so all operands are 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_feat into the feature register, clear neuron counter cnt, go to RUN.
  - RUN: drive core_* from cfg[cnt] through the operand mux. At each clock edge, write core_out into result[cnt]. If cnt==N_NEURONS-1, go to DONE; otherwise cnt++.
  - DONE: out_valid=1; out_result held stable. On out_ready, go to IDLE.
- Config writes: accepted only in IDLE, taking effect at the next edge. A cfg_we in RUN or DONE is dropped and cfg_err pulses the next cycle. A write coincident with a sample accept in IDLE is accepted and applies to that sample.
- In IDLE and DONE, core_* are driven 0.
- Result bits not yet written in the current sample keep their previous value; all are overwritten by DONE.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, busy=0, cfg_err=0, core_*=0, cnt=0, feature register 0.
- Sample accepted at edge T. Neuron i is evaluated in cycle T+1+i. out_valid rises after edge T+N_NEURONS.
- Throughput: N_NEURONS+2 cycles per sample with out_ready held high. No back-to-back accept: in_ready=0 in the cycle out_valid drops.
- Handshake: in_feat is sampled only at the accepting edge and may change afterward. out_valid stays high until out_ready is seen.
- rst mid-RUN or mid-DONE: return to the reset state next edge, drop the sample, and reset config memory.
- The core path is purely combinational within one cycle; its delay counts against the feature-register -> result[cnt] path.

## Structure
- Package tnn_sched_pkg: FEAT_W=3, SRC_W=3, SRC_ZERO=3'd7, CFG_W=18, state enum {IDLE, RUN, DONE}, packed cfg struct {a,b,c,d,e,f : SRC_W}.
- Sub-module tnn_operand_mux: combinational; takes the feature register and one cfg entry, outputs six 3-bit operands. Its zero-index rule is shared with the bench model.

## Test plan
Benches attach an exact core model, core_out = (a+c+e) > (b+d+f), plus one approximate core variant.
- After reset with no config, inject features all 7: expect out_result=0 after 8 RUN cycles, out_valid at accept+9.
- cfg neuron 0 = {a=0,b=3,c=1,d=4,e=2,f=5}, features {7,7,7,0,0,0}: expect out_result[0]=1. Swap features to {0,0,0,7,7,7}: expect bit 0 = 0.
- Set all neurons to source index 6 or 7 while N_FEAT=6: every operand is 0, so out_result=0 regardless of features.
- cfg_we issued during RUN: expect cfg_err pulse, config unchanged, and the next sample's result identical to the previous one.
- Hold out_ready=0 for 20 cycles in DONE: out_valid and out_result stable, in_ready=0, in_valid ignored.
- Assert rst at RUN cycle 3: expect all outputs at reset values the next cycle and config reverted to zero-index.

Source files
------------

// File: rtl/tnn_neuron_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// tnn_sched_pkg
// Shared types and constants for the TNN neuron scheduler.
//   FEAT_W / SRC_W : width of one feature value / one source index
//   SRC_ZERO       : source index that always selects constant 0
//   CFG_W          : width of one neuron config entry (six source indices)
//   state_t        : scheduler FSM states
//   cfg_t          : per-neuron operand routing; slot a sits at the LSBs
// ----------------------------------------------------------------------------
package tnn_sched_pkg;

    localparam int FEAT_W = 3;
    localparam int SRC_W  = 3;
    localparam logic [SRC_W-1:0] SRC_ZERO = 3'd7;
    localparam int CFG_W  = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Declared MSB-first, so 'a' lands in bits [2:0] of the packed word.
    typedef struct packed {
        logic [SRC_W-1:0] f;
        logic [SRC_W-1:0] e;
        logic [SRC_W-1:0] d;
        logic [SRC_W-1:0] c;
        logic [SRC_W-1:0] b;
        logic [SRC_W-1:0] a;
    } cfg_t;

    // Every slot routed to constant 0.
    localparam cfg_t CFG_RESET = {6{SRC_ZERO}};

    // A source index refers to a real feature only below the feature count;
    // everything above (including SRC_ZERO) reads as 0.
    function automatic logic src_is_feat(input logic [SRC_W-1:0] s, input int n_feat);
        return int'(s) < n_feat;
    endfunction

endpackage

// File: rtl/tnn_operand_mux.sv
// ----------------------------------------------------------------------------
// tnn_operand_mux
// Combinational routing of latched sample features onto the six operands of
// the shared neuron core, according to one neuron's config entry.
//   i_feat  : feature register, feature k at [3k+2:3k]
//   i_cfg   : six source indices for the neuron being evaluated
//   o_a..o_f: operands; an index >= N_FEAT yields 0
// ----------------------------------------------------------------------------
module tnn_operand_mux
    import tnn_sched_pkg::*;
#(
    parameter int N_FEAT = 6
) (
    input  logic [FEAT_W*N_FEAT-1:0] i_feat,
    input  cfg_t                     i_cfg,
    output logic [FEAT_W-1:0]        o_a,
    output logic [FEAT_W-1:0]        o_b,
    output logic [FEAT_W-1:0]        o_c,
    output logic [FEAT_W-1:0]        o_d,
    output logic [FEAT_W-1:0]        o_e,
    output logic [FEAT_W-1:0]        o_f
);

    logic [5:0][SRC_W-1:0]  w_src;
    logic [5:0][FEAT_W-1:0] w_op;

    assign w_src = {i_cfg.f, i_cfg.e, i_cfg.d, i_cfg.c, i_cfg.b, i_cfg.a};

    always_comb begin
        w_op = '0;
        for (int k = 0; k < 6; k++) begin
            if (src_is_feat(w_src[k], N_FEAT)) begin
                for (int j = 0; j < N_FEAT; j++) begin
                    if (int'(w_src[k]) == j)
                        w_op[k] = i_feat[FEAT_W*j +: FEAT_W];
                end
            end
        end
    end

    assign o_a = w_op[0];
    assign o_b = w_op[1];
    assign o_c = w_op[2];
    assign o_d = w_op[3];
    assign o_e = w_op[4];
    assign o_f = w_op[5];

endmodule

// File: rtl/tnn_neuron_scheduler.sv
// ----------------------------------------------------------------------------
// tnn_neuron_scheduler
// Time-multiplexes one external combinational TNN neuron core over
// N_NEURONS neurons. One sample is accepted, each neuron is evaluated in
// turn (one per cycle), and the fire vector is returned on a valid/ready port.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_in_valid/o_in_ready : sample handshake, features on i_in_feat
//   i_cfg_we/addr/data    : per-neuron routing writes (IDLE only)
//   o_cfg_err             : one-cycle pulse when a write is dropped
//   o_core_a..f, i_core_out: shared core operands / fire bit
//   o_out_valid/i_out_ready/o_out_result : result handshake
//   o_busy                : sample in flight (RUN or DONE)
// ----------------------------------------------------------------------------
module tnn_neuron_scheduler
    import tnn_sched_pkg::*;
#(
    parameter  int N_NEURONS = 8,
    parameter  int N_FEAT    = 6,
    localparam int CNT_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [FEAT_W*N_FEAT-1:0] i_in_feat,
    input  logic                     i_cfg_we,
    input  logic [CNT_W-1:0]         i_cfg_addr,
    input  logic [CFG_W-1:0]         i_cfg_data,
    output logic                     o_cfg_err,
    output logic [FEAT_W-1:0]        o_core_a,
    output logic [FEAT_W-1:0]        o_core_b,
    output logic [FEAT_W-1:0]        o_core_c,
    output logic [FEAT_W-1:0]        o_core_d,
    output logic [FEAT_W-1:0]        o_core_e,
    output logic [FEAT_W-1:0]        o_core_f,
    input  logic                     i_core_out,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [N_NEURONS-1:0]     o_out_result,
    output logic                     o_busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_NEURONS - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [FEAT_W*N_FEAT-1:0]  r_feat;
    cfg_t                      r_cfg [N_NEURONS];
    logic [N_NEURONS-1:0]      r_result;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_busy;
    logic                      r_cfg_err;

    logic                      w_addr_ok;
    logic                      w_run;
    logic [FEAT_W-1:0]         w_a, w_b, w_c, w_d, w_e, w_f;

    // Out-of-range addresses (non power-of-two N_NEURONS) are dropped too.
    assign w_addr_ok = int'(i_cfg_addr) < N_NEURONS;
    assign w_run     = (r_state == RUN);

    // ---------------- config memory ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < N_NEURONS; n++)
                r_cfg[n] <= CFG_RESET;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_we && ((r_state != IDLE) || !w_addr_ok);
            if (i_cfg_we && (r_state == IDLE) && w_addr_ok)
                r_cfg[i_cfg_addr] <= cfg_t'(i_cfg_data);
        end
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_feat      <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_feat     <= i_in_feat;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_result[r_cnt] <= i_core_out;
                    if (r_cnt == LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- operand routing to the shared core ----------------
    tnn_operand_mux #(
        .N_FEAT (N_FEAT)
    ) u_mux (
        .i_feat (r_feat),
        .i_cfg  (r_cfg[r_cnt]),
        .o_a    (w_a),
        .o_b    (w_b),
        .o_c    (w_c),
        .o_d    (w_d),
        .o_e    (w_e),
        .o_f    (w_f)
    );

    // Core is quiet outside RUN so its output never toggles needlessly.
    assign o_core_a = w_run ? w_a : '0;
    assign o_core_b = w_run ? w_b : '0;
    assign o_core_c = w_run ? w_c : '0;
    assign o_core_d = w_run ? w_d : '0;
    assign o_core_e = w_run ? w_e : '0;
    assign o_core_f = w_run ? w_f : '0;

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_out_result = r_result;
    assign o_busy       = r_busy;
    assign o_cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_tnn_neuron_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tnn_neuron_scheduler
// Directed + randomized bench for tnn_neuron_scheduler with an external core
// model (exact or approximate) and a reference model of the expected fire
// vector computed from the routing rules.
// ----------------------------------------------------------------------------
module tb_tnn_neuron_scheduler;

    localparam int N  = 8;
    localparam int NF = 6;
    localparam int CW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid, in_ready;
    logic [3*NF-1:0] in_feat;
    logic            cfg_we;
    logic [CW-1:0]   cfg_addr;
    logic [17:0]     cfg_data;
    logic            cfg_err;
    logic [2:0]      core_a, core_b, core_c, core_d, core_e, core_f;
    logic            core_out;
    logic            out_valid, out_ready;
    logic [N-1:0]    out_result;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int cfg_m [N][6];
    int feat_m [NF];
    bit approx = 1'b0;

    always #5 clk = ~clk;

    tnn_neuron_scheduler #(.N_NEURONS(N), .N_FEAT(NF)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_feat(in_feat),
        .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr), .i_cfg_data(cfg_data), .o_cfg_err(cfg_err),
        .o_core_a(core_a), .o_core_b(core_b), .o_core_c(core_c),
        .o_core_d(core_d), .o_core_e(core_e), .o_core_f(core_f),
        .i_core_out(core_out),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_result(out_result),
        .o_busy(busy)
    );

    // Exact core, or an approximate variant that ignores operand LSBs.
    function automatic logic core_fn(input int a, b, c, d, e, f, input bit ap);
        if (ap) begin
            a = a / 2; b = b / 2; c = c / 2; d = d / 2; e = e / 2; f = f / 2;
        end
        return (a + c + e) > (b + d + f);
    endfunction

    assign core_out = core_fn(int'(core_a), int'(core_b), int'(core_c),
                              int'(core_d), int'(core_e), int'(core_f), approx);

    // ---------------- reference model ----------------
    function automatic logic [17:0] exp_ops(input int n);
        logic [17:0] r;
        r = '0;
        for (int k = 0; k < 6; k++)
            if (cfg_m[n][k] < NF) r[3*k +: 3] = 3'(feat_m[cfg_m[n][k]]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_result();
        logic [N-1:0] r;
        logic [17:0]  o;
        for (int n = 0; n < N; n++) begin
            o = exp_ops(n);
            r[n] = core_fn(int'(o[2:0]), int'(o[5:3]), int'(o[8:6]),
                           int'(o[11:9]), int'(o[14:12]), int'(o[17:15]), approx);
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_feats();
        for (int k = 0; k < NF; k++) in_feat[3*k +: 3] = 3'(feat_m[k]);
    endtask

    task automatic set_cfg_model(input int addr, input logic [17:0] d);
        for (int k = 0; k < 6; k++) cfg_m[addr][k] = int'(d[3*k +: 3]);
    endtask

    task automatic cfg_write(input int addr, input logic [17:0] d);
        cfg_we = 1'b1; cfg_addr = CW'(addr); cfg_data = d;
        set_cfg_model(addr, d);
        tick();
        cfg_we = 1'b0;
        check("cfg_err_idle", cfg_err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_result"},    out_result, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_cfg_err"},   cfg_err, 0);
        check({tag, "_core"}, {core_f, core_e, core_d, core_c, core_b, core_a}, 0);
    endtask

    // One full sample. poke: RUN cycle in which a (dropped) cfg write is
    // issued, -1 for none. hold: DONE cycles with out_ready low.
    // coincide: issue a legal cfg write together with the accept.
    task automatic run_sample(input int poke, input int hold, input bit coincide,
                              output logic [N-1:0] res);
        logic [N-1:0] exp_r;
        logic [17:0]  d;
        int           addr;
        int           cnt;
        drive_feats();
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        if (coincide) begin
            addr = int'($urandom_range(0, N-1));
            d    = 18'($urandom);
            cfg_we = 1'b1; cfg_addr = CW'(addr); cfg_data = d;
            set_cfg_model(addr, d);
        end
        exp_r = exp_result();
        tick();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_feat  = 18'($urandom);
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
        for (int i = 0; i < N; i++) begin
            check("core_ops", {core_f, core_e, core_d, core_c, core_b, core_a}, exp_ops(i));
            check("valid_in_run", out_valid, 0);
            if (i == poke) begin
                cfg_we = 1'b1; cfg_addr = CW'($urandom); cfg_data = 18'($urandom);
            end
            tick();
            cfg_we = 1'b0;
            if (i == poke) check("cfg_err_run", cfg_err, 1);
        end
        cnt = N;
        while (!out_valid && cnt < N + 40) begin
            tick();
            cnt++;
        end
        check("latency", cnt, N);
        check("result", out_result, exp_r);
        check("core_idle_done", {core_f, core_e, core_d, core_c, core_b, core_a}, 0);
        res = out_result;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_feat  = 18'($urandom);
            if (h == 0) begin
                cfg_we = 1'b1; cfg_addr = CW'($urandom); cfg_data = 18'($urandom);
            end
            tick();
            cfg_we = 1'b0;
            if (h == 0) check("cfg_err_done", cfg_err, 1);
            check("hold_valid", out_valid, 1);
            check("hold_result", out_result, exp_r);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_back", in_ready, 1);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] res, res1, res2;
        rst = 1'b1; in_valid = 1'b0; in_feat = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; out_ready = 1'b0;
        for (int n = 0; n < N; n++) for (int k = 0; k < 6; k++) cfg_m[n][k] = 7;
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Default config: all operands zero, nothing fires.
        for (int k = 0; k < NF; k++) feat_m[k] = 7;
        run_sample(-1, 0, 0, res);
        check("default_zero", res, 0);

        // Neuron 0 compares features {0,1,2} against {3,4,5}.
        cfg_write(0, {3'd5, 3'd2, 3'd4, 3'd1, 3'd3, 3'd0});
        feat_m = '{7, 7, 7, 0, 0, 0};
        run_sample(-1, 0, 0, res);
        check("n0_fire", res[0], 1);
        feat_m = '{0, 0, 0, 7, 7, 7};
        run_sample(-1, 0, 0, res);
        check("n0_nofire", res[0], 0);

        // Indices 6 and 7 both read as zero with six features.
        for (int n = 0; n < N; n++) begin
            logic [17:0] d;
            for (int k = 0; k < 6; k++) d[3*k +: 3] = 3'($urandom_range(6, 7));
            cfg_write(n, d);
        end
        for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(0, 7));
        run_sample(-1, 0, 0, res);
        check("zero_index_all", res, 0);

        // Dropped write in RUN leaves config and results unchanged.
        for (int n = 0; n < N; n++) cfg_write(n, 18'($urandom));
        for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(0, 7));
        run_sample(-1, 0, 0, res1);
        run_sample(3, 0, 0, res2);
        check("run_write_dropped", res2, res1);

        // Back-pressure in DONE for 20 cycles.
        for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(0, 7));
        run_sample(-1, 20, 0, res);

        // Reset in RUN cycle 3 drops the sample and restores zero routing.
        for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(0, 7));
        drive_feats();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < N; n++) for (int k = 0; k < 6; k++) cfg_m[n][k] = 7;
        check_reset_outputs("mid_rst");
        for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(1, 7));
        run_sample(-1, 0, 0, res);
        check("cfg_reverted", res, 0);

        // Randomized samples over both core variants.
        for (int it = 0; it < 30; it++) begin
            approx = it[0];
            for (int w = 0; w < int'($urandom_range(0, 3)); w++)
                cfg_write(int'($urandom_range(0, N-1)), 18'($urandom));
            for (int k = 0; k < NF; k++) feat_m[k] = int'($urandom_range(0, 7));
            run_sample(-1, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), res);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
